loop_scan_sequencer: RTL and testbench

//   Programmable two-level (row x column) scan controller that sequences the 8-bit

---
 rtl/seq_pkg.sv | 14 +
 rtl/scan_index_counter.sv | 40 ++++
 rtl/loop_scan_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_loop_scan_sequencer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared types and default widths for the loop scan sequencer.
// The optional cycle counter is enabled by defining SEQ_CYCLE_COUNT_EN.
package seq_pkg;

    localparam int CNT_W_DEF  = 8;
    localparam int PERF_W_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } seq_state_t;

endpackage

// File: rtl/scan_index_counter.sv
// Index counter with load-clear, increment enable and terminal-count flag.
// tc is high when the count sits on limit-1; the owner decides when to wrap.
module scan_index_counter
    import seq_pkg::*;
#(
    parameter int W = CNT_W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         inc,
    input  logic [W-1:0] limit,
    output logic [W-1:0] cnt,
    output logic         tc
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] cnt_r;
    logic [W-1:0] last_s;

    assign last_s = limit - ONE;

    // index register: clear wins over increment
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_r <= {W{1'b0}};
        end else if (clear) begin
            cnt_r <= {W{1'b0}};
        end else if (inc) begin
            cnt_r <= cnt_r + ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt = cnt_r;
    assign tc  = (cnt_r == last_s);

endmodule

// File: rtl/loop_scan_sequencer.sv
// Row x column scan controller issuing index pairs over a valid/ready handshake.
// Define SEQ_CYCLE_COUNT_EN to build the saturating RUN-cycle counter on cycle_cnt_o.
module loop_scan_sequencer
    import seq_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int PERF_W = PERF_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [CNT_W-1:0]  num_row_i,
    input  logic [CNT_W-1:0]  num_col_i,
    input  logic              ready_i,
    output logic [CNT_W-1:0]  row_o,
    output logic [CNT_W-1:0]  col_o,
    output logic              valid_o,
    output logic              row_last_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [PERF_W-1:0] cycle_cnt_o
);

    localparam logic [CNT_W-1:0] ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] ZERO = {CNT_W{1'b0}};

    seq_state_t       state_r;
    logic [CNT_W-1:0] num_row_r;
    logic [CNT_W-1:0] num_col_r;
    logic             valid_r;
    logic             row_last_r;
    logic             busy_r;
    logic             done_r;

    logic             start_acc_s;
    logic             beat_s;
    logic             row_clear_s;
    logic             row_inc_s;
    logic             col_clear_s;
    logic             col_inc_s;
    logic             row_tc_s;
    logic             col_tc_s;
    logic [CNT_W-1:0] row_cnt_s;
    logic [CNT_W-1:0] col_cnt_s;
    logic             col_next_last_s;

    // counter control derived from the handshake; column is the inner loop
    always_comb begin
        start_acc_s     = 1'b0;
        beat_s          = 1'b0;
        col_clear_s     = 1'b0;
        col_inc_s       = 1'b0;
        row_clear_s     = 1'b0;
        row_inc_s       = 1'b0;
        if (state_r == ST_IDLE) begin
            start_acc_s = start_i;
        end else begin
            start_acc_s = 1'b0;
        end
        if (state_r == ST_RUN) begin
            beat_s = ready_i;
        end else begin
            beat_s = 1'b0;
        end
        col_clear_s = start_acc_s | (beat_s & col_tc_s);
        col_inc_s   = beat_s & ~col_tc_s;
        row_clear_s = start_acc_s;
        row_inc_s   = beat_s & col_tc_s & ~row_tc_s;
    end

    assign col_next_last_s = ((col_cnt_s + ONE) == (num_col_r - ONE));

    scan_index_counter #(.W(CNT_W)) u_row_cnt (
        .clk   (clk),
        .rst   (rst),
        .clear (row_clear_s),
        .inc   (row_inc_s),
        .limit (num_row_r),
        .cnt   (row_cnt_s),
        .tc    (row_tc_s)
    );

    scan_index_counter #(.W(CNT_W)) u_col_cnt (
        .clk   (clk),
        .rst   (rst),
        .clear (col_clear_s),
        .inc   (col_inc_s),
        .limit (num_col_r),
        .cnt   (col_cnt_s),
        .tc    (col_tc_s)
    );

    // sequencer FSM; row_last is precomputed for the pair that will be shown next
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            num_row_r  <= ZERO;
            num_col_r  <= ZERO;
            valid_r    <= 1'b0;
            row_last_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (start_i) begin
                        num_row_r <= num_row_i;
                        num_col_r <= num_col_i;
                        busy_r    <= 1'b1;
                        if ((num_row_i == ZERO) || (num_col_i == ZERO)) begin
                            state_r    <= ST_DONE;
                            valid_r    <= 1'b0;
                            row_last_r <= 1'b0;
                            done_r     <= 1'b1;
                        end else begin
                            state_r    <= ST_RUN;
                            valid_r    <= 1'b1;
                            row_last_r <= (num_col_i == ONE);
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (beat_s) begin
                        if (col_tc_s && row_tc_s) begin
                            state_r    <= ST_DONE;
                            valid_r    <= 1'b0;
                            row_last_r <= 1'b0;
                            done_r     <= 1'b1;
                        end else if (col_tc_s) begin
                            row_last_r <= (num_col_r == ONE);
                        end else begin
                            row_last_r <= col_next_last_s;
                        end
                    end else begin
                        row_last_r <= row_last_r;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    valid_r <= 1'b0;
                end
                default: begin
                    state_r    <= ST_IDLE;
                    valid_r    <= 1'b0;
                    row_last_r <= 1'b0;
                    busy_r     <= 1'b0;
                    done_r     <= 1'b0;
                end
            endcase
        end
    end

`ifdef SEQ_CYCLE_COUNT_EN
    logic [PERF_W-1:0] cycle_cnt_r;

    // RUN-cycle counter, saturating, cleared by an accepted start
    always_ff @(posedge clk) begin
        if (!rst) begin
            cycle_cnt_r <= {PERF_W{1'b0}};
        end else if (start_acc_s) begin
            cycle_cnt_r <= {PERF_W{1'b0}};
        end else if ((state_r == ST_RUN) && (cycle_cnt_r != {PERF_W{1'b1}})) begin
            cycle_cnt_r <= cycle_cnt_r + {{(PERF_W-1){1'b0}}, 1'b1};
        end else begin
            cycle_cnt_r <= cycle_cnt_r;
        end
    end

    assign cycle_cnt_o = cycle_cnt_r;
`else
    assign cycle_cnt_o = {PERF_W{1'b0}};
`endif

    assign row_o      = row_cnt_s;
    assign col_o      = col_cnt_s;
    assign valid_o    = valid_r;
    assign row_last_o = row_last_r;
    assign busy_o     = busy_r;
    assign done_o     = done_r;

endmodule

// File: tb/tb_loop_scan_sequencer.sv
// Directed self-checking bench for loop_scan_sequencer.
// Cycle-count expectation follows SEQ_CYCLE_COUNT_EN.
module tb_loop_scan_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic [7:0]  num_row_i;
    logic [7:0]  num_col_i;
    logic        ready_i;
    logic [7:0]  row_o;
    logic [7:0]  col_o;
    logic        valid_o;
    logic        row_last_o;
    logic        busy_o;
    logic        done_o;
    logic [15:0] cycle_cnt_o;

    int checks   = 0;
    int failures = 0;

`ifdef SEQ_CYCLE_COUNT_EN
    localparam logic [15:0] EXP_CYC = 16'd11;
`else
    localparam logic [15:0] EXP_CYC = 16'd0;
`endif

    loop_scan_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .num_row_i   (num_row_i),
        .num_col_i   (num_col_i),
        .ready_i     (ready_i),
        .row_o       (row_o),
        .col_o       (col_o),
        .valid_o     (valid_o),
        .row_last_o  (row_last_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .cycle_cnt_o (cycle_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_ctl(input string tag, input logic ev, input logic el,
                              input logic eb, input logic ed);
        checks++;
        assert (valid_o === ev) else begin
            failures++;
            $error("FAIL %s valid_o observed=%0b expected=%0b", tag, valid_o, ev);
        end
        checks++;
        assert (row_last_o === el) else begin
            failures++;
            $error("FAIL %s row_last_o observed=%0b expected=%0b", tag, row_last_o, el);
        end
        checks++;
        assert (busy_o === eb) else begin
            failures++;
            $error("FAIL %s busy_o observed=%0b expected=%0b", tag, busy_o, eb);
        end
        checks++;
        assert (done_o === ed) else begin
            failures++;
            $error("FAIL %s done_o observed=%0b expected=%0b", tag, done_o, ed);
        end
    endtask

    task automatic expect_out(input string tag, input logic ev, input logic [7:0] er,
                              input logic [7:0] ec, input logic el, input logic eb,
                              input logic ed);
        expect_ctl(tag, ev, el, eb, ed);
        checks++;
        assert (row_o === er) else begin
            failures++;
            $error("FAIL %s row_o observed=%0d expected=%0d", tag, row_o, er);
        end
        checks++;
        assert (col_o === ec) else begin
            failures++;
            $error("FAIL %s col_o observed=%0d expected=%0d", tag, col_o, ec);
        end
    endtask

    task automatic start_scan(input logic [7:0] r, input logic [7:0] c);
        start_i   = 1'b1;
        num_row_i = r;
        num_col_i = c;
        tick();
        start_i   = 1'b0;
    endtask

    initial begin
        int  idx;
        logic got_done;

        rst       = 1'b0;
        start_i   = 1'b0;
        num_row_i = 8'd0;
        num_col_i = 8'd0;
        ready_i   = 1'b0;
        tick();
        tick();
        expect_out("reset", 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
        checks++;
        assert (cycle_cnt_o === 16'd0) else begin
            failures++;
            $error("FAIL reset_cyc observed=%0d expected=0", cycle_cnt_o);
        end
        rst = 1'b1;
        tick();

        // 2x3 scan, ready always high
        ready_i = 1'b1;
        start_scan(8'd2, 8'd3);
        for (int k = 0; k < 6; k++) begin
            expect_out($sformatf("s23_beat%0d", k), 1'b1, 8'(k / 3), 8'(k % 3),
                       (k % 3) == 2, 1'b1, 1'b0);
            tick();
        end
        expect_ctl("s23_done", 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        expect_ctl("s23_idle", 1'b0, 1'b0, 1'b0, 1'b0);

        // 2x2 scan with ready low on alternate cycles
        ready_i = 1'b0;
        start_scan(8'd2, 8'd2);
        idx = 0;
        for (int c = 0; c < 8; c++) begin
            expect_out($sformatf("s22_cyc%0d", c), 1'b1, 8'(idx / 2), 8'(idx % 2),
                       (idx % 2) == 1, 1'b1, 1'b0);
            ready_i = c[0];
            tick();
            if (ready_i) idx++;
        end
        expect_ctl("s22_done", 1'b0, 1'b0, 1'b1, 1'b1);
        tick();

        // zero extents finish without issuing a pair
        ready_i = 1'b1;
        start_scan(8'd0, 8'd5);
        expect_ctl("r0_done", 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        expect_ctl("r0_idle", 1'b0, 1'b0, 1'b0, 1'b0);
        start_scan(8'd4, 8'd0);
        expect_ctl("c0_done", 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        expect_ctl("c0_idle", 1'b0, 1'b0, 1'b0, 1'b0);

        // restart mid-scan with other extents is ignored
        start_scan(8'd2, 8'd2);
        expect_out("ign_00", 1'b1, 8'd0, 8'd0, 1'b0, 1'b1, 1'b0);
        tick();
        expect_out("ign_01", 1'b1, 8'd0, 8'd1, 1'b1, 1'b1, 1'b0);
        start_scan(8'd5, 8'd5);
        expect_out("ign_10", 1'b1, 8'd1, 8'd0, 1'b0, 1'b1, 1'b0);
        tick();
        expect_out("ign_11", 1'b1, 8'd1, 8'd1, 1'b1, 1'b1, 1'b0);
        tick();
        expect_ctl("ign_done", 1'b0, 1'b0, 1'b1, 1'b1);
        tick();

        // reset during pair (1,1) of a 3x3 scan, then a 1x1 scan
        start_scan(8'd3, 8'd3);
        for (int k = 0; k < 4; k++) tick();
        expect_out("rst_pre", 1'b1, 8'd1, 8'd1, 1'b0, 1'b1, 1'b0);
        rst = 1'b0;
        tick();
        expect_out("rst_mid", 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
        checks++;
        assert (cycle_cnt_o === 16'd0) else begin
            failures++;
            $error("FAIL rst_mid_cyc observed=%0d expected=0", cycle_cnt_o);
        end
        rst = 1'b1;
        start_scan(8'd1, 8'd1);
        expect_out("s11_beat", 1'b1, 8'd0, 8'd0, 1'b1, 1'b1, 1'b0);
        tick();
        expect_ctl("s11_done", 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        expect_ctl("s11_idle", 1'b0, 1'b0, 1'b0, 1'b0);

        // 3x3 scan with two stall cycles for the cycle counter
        ready_i = 1'b0;
        start_scan(8'd3, 8'd3);
        got_done = 1'b0;
        for (int c = 0; c < 40; c++) begin
            ready_i = (c >= 2);
            tick();
            if (done_o) begin
                got_done = 1'b1;
                break;
            end
        end
        checks++;
        assert (got_done === 1'b1) else begin
            failures++;
            $error("FAIL cyc_done_timeout observed=%0b expected=1", got_done);
        end
        checks++;
        assert (cycle_cnt_o === EXP_CYC) else begin
            failures++;
            $error("FAIL cyc_cnt observed=%0d expected=%0d", cycle_cnt_o, EXP_CYC);
        end
        tick();
        checks++;
        assert (cycle_cnt_o === EXP_CYC) else begin
            failures++;
            $error("FAIL cyc_hold observed=%0d expected=%0d", cycle_cnt_o, EXP_CYC);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
